// File: rtl/jtbubl_snd_comm_pkg.sv
// Shared definitions for the main/sound CPU mailbox.
// Holds the register map for both CPU sides, the status bit positions
// and the reset-stretch state encoding.
package jtbubl_snd_comm_pkg;

  // Main CPU register map
  localparam logic [1:0] MAIN_ADDR_DATA = 2'd0;  // wr: m2s latch, rd: s2m latch
  localparam logic [1:0] MAIN_ADDR_STAT = 2'd1;  // rd: status, clears overrun
  localparam logic [1:0] MAIN_ADDR_SRST = 2'd3;  // wr: bit0 = sound reset request

  // Sound CPU register map
  localparam logic [1:0] SND_ADDR_DATA    = 2'd0;  // rd: m2s latch (NMI ack), wr: s2m latch
  localparam logic [1:0] SND_ADDR_STAT    = 2'd1;  // rd: status
  localparam logic [1:0] SND_ADDR_NMI_DIS = 2'd1;  // wr: disable NMI
  localparam logic [1:0] SND_ADDR_NMI_EN  = 2'd2;  // wr: enable NMI

  // Status bit positions
  localparam int unsigned STAT_S2M_FULL = 0;
  localparam int unsigned STAT_M2S_FULL = 1;
  localparam int unsigned STAT_OVR      = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_STRETCH = 2'd2
  } rst_st_e;

endpackage

// File: rtl/jtbubl_comm_latch.sv
// One direction of the mailbox: 8-bit data register plus full flag.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   wr_i         : load din_i and set full (set wins over clr_i)
//   clr_i        : reader acknowledge, clears full
//   hold_i       : forces full to 0 (data retained)
//   din_i        : write data
//   data_o       : latched data
//   full_o       : full flag
//   ovr_o        : write landed while already full (same-cycle pulse)
module jtbubl_comm_latch (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_i,
  input  logic       clr_i,
  input  logic       hold_i,
  input  logic [7:0] din_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       ovr_o
);
  import jtbubl_snd_comm_pkg::*;

  logic [7:0] data_q, data_d;
  logic       full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (wr_i) data_d = din_i;
    if (hold_i)     full_d = 1'b0;
    else if (wr_i)  full_d = 1'b1;
    else if (clr_i) full_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;
  assign ovr_o  = wr_i & full_q;

endmodule

// File: rtl/jtbubl_snd_comm.sv
// Bidirectional main-CPU / sound-CPU mailbox for Bubble Bobble.
// One latch per direction, NMI generation towards the sound Z80 with
// sound-side enable, and a main-controlled sound reset with a minimum
// length of RST_TICKS cen12 ticks.
// Ports:
//   clk, rst, cen12              : clock, sync reset, 12 MHz enable
//   main_cs/rnw/addr/din/dout    : main CPU access port, registered read data
//   snd_cs/rnw/addr/din/dout     : sound CPU access port, registered read data
//   snd_nmin                     : active-low NMI level to sound CPU
//   snd_rst                      : active-high reset to sound CPU
module jtbubl_snd_comm #(
  parameter int unsigned RST_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen12,
  input  logic       main_cs,
  input  logic       main_rnw,
  input  logic [1:0] main_addr,
  input  logic [7:0] main_din,
  output logic [7:0] main_dout,
  input  logic       snd_cs,
  input  logic       snd_rnw,
  input  logic [1:0] snd_addr,
  input  logic [7:0] snd_din,
  output logic [7:0] snd_dout,
  output logic       snd_nmin,
  output logic       snd_rst
);
  import jtbubl_snd_comm_pkg::*;

  localparam int unsigned CW = $clog2(RST_TICKS + 1);
  localparam logic [CW-1:0] TICKS = CW'(RST_TICKS);

  logic [7:0] m2s_data, s2m_data;
  logic       m2s_full, s2m_full, m2s_ovr, s2m_ovr_unused;

  logic       ovr_q, ovr_d;
  logic       nmi_pend_q, nmi_pend_d;
  logic       nmi_en_q, nmi_en_d;
  logic       rst_req_q, rst_req_d;
  rst_st_e    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] main_dout_q, main_dout_d;
  logic [7:0] snd_dout_q, snd_dout_d;

  // Access decode; the sound side is deaf while it is held in reset
  logic m_wr, m_rd, s_acc, s_wr, s_rd;
  logic m_wr0, m_rd0, m_rd1, m_wr3;
  logic s_wr0, s_rd0, s_rd1, s_wr1, s_wr2;

  assign m_wr  = main_cs & ~main_rnw;
  assign m_rd  = main_cs &  main_rnw;
  assign s_acc = snd_cs & ~snd_rst;
  assign s_wr  = s_acc & ~snd_rnw;
  assign s_rd  = s_acc &  snd_rnw;

  assign m_wr0 = m_wr && main_addr == MAIN_ADDR_DATA;
  assign m_wr3 = m_wr && main_addr == MAIN_ADDR_SRST;
  assign m_rd0 = m_rd && main_addr == MAIN_ADDR_DATA;
  assign m_rd1 = m_rd && main_addr == MAIN_ADDR_STAT;
  assign s_wr0 = s_wr && snd_addr == SND_ADDR_DATA;
  assign s_wr1 = s_wr && snd_addr == SND_ADDR_NMI_DIS;
  assign s_wr2 = s_wr && snd_addr == SND_ADDR_NMI_EN;
  assign s_rd0 = s_rd && snd_addr == SND_ADDR_DATA;
  assign s_rd1 = s_rd && snd_addr == SND_ADDR_STAT;

  jtbubl_comm_latch u_m2s (
    .clk_i  (clk),
    .rst_i  (rst),
    .wr_i   (m_wr0),
    .clr_i  (s_rd0),
    .hold_i (1'b0),
    .din_i  (main_din),
    .data_o (m2s_data),
    .full_o (m2s_full),
    .ovr_o  (m2s_ovr)
  );

  jtbubl_comm_latch u_s2m (
    .clk_i  (clk),
    .rst_i  (rst),
    .wr_i   (s_wr0),
    .clr_i  (m_rd0),
    .hold_i (snd_rst),
    .din_i  (snd_din),
    .data_o (s2m_data),
    .full_o (s2m_full),
    .ovr_o  (s2m_ovr_unused)
  );

  always_comb begin
    ovr_d       = ovr_q;
    nmi_pend_d  = nmi_pend_q;
    nmi_en_d    = nmi_en_q;
    rst_req_d   = rst_req_q;
    main_dout_d = main_dout_q;
    snd_dout_d  = snd_dout_q;

    if (m2s_ovr)    ovr_d = 1'b1;
    else if (m_rd1) ovr_d = 1'b0;

    if (snd_rst)    nmi_pend_d = 1'b0;
    else if (m_wr0) nmi_pend_d = 1'b1;
    else if (s_rd0) nmi_pend_d = 1'b0;

    if (snd_rst)    nmi_en_d = 1'b0;
    else if (s_wr1) nmi_en_d = 1'b0;
    else if (s_wr2) nmi_en_d = 1'b1;

    if (m_wr3) rst_req_d = main_din[0];

    if (m_rd) begin
      if (m_rd0)      main_dout_d = s2m_data;
      else if (m_rd1) begin
        main_dout_d = '0;
        main_dout_d[STAT_OVR]      = ovr_q;
        main_dout_d[STAT_M2S_FULL] = m2s_full;
        main_dout_d[STAT_S2M_FULL] = s2m_full;
      end else        main_dout_d = '1;
    end

    if (s_rd) begin
      if (s_rd0)      snd_dout_d = m2s_data;
      else if (s_rd1) begin
        snd_dout_d = '0;
        snd_dout_d[STAT_M2S_FULL] = m2s_full;
        snd_dout_d[STAT_S2M_FULL] = s2m_full;
      end else        snd_dout_d = '1;
    end
  end

  // Counter runs across HOLD and STRETCH so a re-asserted request does not
  // restart the minimum pulse; it is cleared only on entry from IDLE.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (st_q != ST_IDLE && cen12 && cnt_q != TICKS) cnt_d = cnt_q + 1'b1;
    case (st_q)
      ST_IDLE: if (rst_req_q) begin
        st_d  = ST_HOLD;
        cnt_d = '0;
      end
      ST_HOLD:    if (!rst_req_q) st_d = ST_STRETCH;
      ST_STRETCH: begin
        if (rst_req_q)          st_d = ST_HOLD;
        else if (cnt_q == TICKS) st_d = ST_IDLE;
      end
      default: st_d = ST_STRETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q       <= 1'b0;
      nmi_pend_q  <= 1'b0;
      nmi_en_q    <= 1'b0;
      rst_req_q   <= 1'b0;
      main_dout_q <= '0;
      snd_dout_q  <= '0;
      st_q        <= ST_STRETCH;
      cnt_q       <= '0;
    end else begin
      ovr_q       <= ovr_d;
      nmi_pend_q  <= nmi_pend_d;
      nmi_en_q    <= nmi_en_d;
      rst_req_q   <= rst_req_d;
      main_dout_q <= main_dout_d;
      snd_dout_q  <= snd_dout_d;
      st_q        <= st_d;
      cnt_q       <= cnt_d;
    end
  end

  assign snd_rst   = st_q != ST_IDLE;
  // Gated by snd_rst so NMI deasserts together with reset entry, before the
  // pending/enable flags are cleared a cycle later.
  assign snd_nmin  = ~(nmi_pend_q & nmi_en_q & ~snd_rst);
  assign main_dout = main_dout_q;
  assign snd_dout  = snd_dout_q;

endmodule
